hamming_frame_encoder: RTL and testbench

- Upstream stage of the Hamming(7,4) decoder. Accepts 4-bit data words over a valid/ready handshake.
- Encodes each word into a 7-bit codeword with selectable even/odd parity, and can optionally flip one bit to inject an error.
- Presents each codeword in parallel (the decoder's x/select inputs) and shifts it out serially, MSB first, on a framed bit stream for link-level test.

---
 rtl/hamming_frame_encoder.sv | 145 ++++++++++++++
 tb/tb_hamming_frame_encoder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_frame_encoder.sv
// Hamming(7,4) encoder with optional single-bit error injection.
// Codewords are presented in parallel and shifted out MSB-first as framed serial bits.
module hamming_frame_encoder #(
  parameter int GAP_CYCLES = 1,
  parameter int COUNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_data,
  input  logic               in_parity_odd,
  input  logic [2:0]         in_err_pos,
  output logic [6:0]         cw_out,
  output logic               cw_odd,
  output logic               cw_valid,
  output logic               ser_out,
  output logic               ser_sof,
  output logic               ser_busy,
  output logic [COUNT_W-1:0] frame_count
);

  // state | meaning
  // IDLE  | shifter empty; loads hold register when it is full
  // SHIFT | driving codeword bits, bit_cnt 0..6
  // GAP   | inter-frame idle for GAP_CYCLES cycles
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t          state, state_nxt;
  logic [6:0]      hold_cw;
  logic            hold_odd;
  logic            hold_full;
  logic [6:0]      shifter;
  logic [2:0]      bit_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            accept;
  logic            load;
  logic            last_bit;
  logic            gap_done;

  function automatic logic [6:0] encode(input logic [3:0] d, input logic odd,
                                        input logic [2:0] err);
    logic       p1, p2, p3;
    logic [6:0] cw;
    p1 = d[3] ^ d[2] ^ d[0] ^ odd;
    p2 = d[3] ^ d[1] ^ d[0] ^ odd;
    p3 = d[2] ^ d[1] ^ d[0] ^ odd;
    cw = {p1, p2, d[3], p3, d[2], d[1], d[0]};
    if (err != 3'd0) cw[3'd7 - err] = ~cw[3'd7 - err];
    return cw;
  endfunction

  assign in_ready = !hold_full;
  assign accept   = in_valid && !hold_full;
  assign last_bit = (state == SHIFT) && (bit_cnt == 3'd6);
  assign gap_done = (gap_cnt == '0);
  // Back-to-back reload straight from the last bit only happens without a gap.
  assign load     = hold_full && ((state == IDLE) || (last_bit && (GAP_CYCLES == 0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (hold_full) state_nxt = SHIFT;
      SHIFT: begin
        if (bit_cnt == 3'd6) begin
          if (GAP_CYCLES > 0)  state_nxt = GAP;
          else if (hold_full)  state_nxt = SHIFT;
          else                 state_nxt = IDLE;
        end
      end
      GAP:   if (gap_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ser_out  = 1'b0;
    ser_sof  = 1'b0;
    ser_busy = 1'b0;
    if (state == SHIFT) begin
      ser_out  = shifter[6];
      ser_sof  = (bit_cnt == 3'd0);
      ser_busy = 1'b1;
    end
  end

  // Accept and load are mutually exclusive: load needs hold_full, accept needs !hold_full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cw   <= '0;
      hold_odd  <= 1'b0;
      hold_full <= 1'b0;
    end else if (load) begin
      hold_full <= 1'b0;
    end else if (accept) begin
      hold_cw   <= encode(in_data, in_parity_odd, in_err_pos);
      hold_odd  <= in_parity_odd;
      hold_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shifter <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shifter <= hold_cw;
      bit_cnt <= '0;
    end else if (state == SHIFT) begin
      shifter <= {shifter[5:0], 1'b0};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        gap_cnt <= '0;
    else if (last_bit)                 gap_cnt <= GAP_LOAD;
    else if (state == GAP && !gap_done) gap_cnt <= gap_cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cw_out      <= '0;
      cw_odd      <= 1'b0;
      cw_valid    <= 1'b0;
      frame_count <= '0;
    end else begin
      cw_valid <= load;
      if (load) begin
        cw_out      <= hold_cw;
        cw_odd      <= hold_odd;
        frame_count <= frame_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hamming_frame_encoder.sv
// Scoreboard bench: driver pushes hand-computed codewords, monitor checks parallel and serial output.
module tb_hamming_frame_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid, in_parity_odd;
  logic [3:0] in_data;
  logic [2:0] in_err_pos;
  logic       in_ready;
  logic [6:0] cw_out;
  logic       cw_odd, cw_valid, ser_out, ser_sof, ser_busy;
  logic [1:0] frame_count;

  logic       vb, odd_b, ready_b;
  logic [3:0] data_b;
  logic [2:0] err_b;
  logic [6:0] cw_b;
  logic       cw_odd_b, cw_valid_b, ser_b, sof_b, busy_b;
  logic [7:0] frame_count_b;

  always #5 clk = ~clk;

  hamming_frame_encoder #(.GAP_CYCLES(1), .COUNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_parity_odd(in_parity_odd), .in_err_pos(in_err_pos),
    .cw_out(cw_out), .cw_odd(cw_odd), .cw_valid(cw_valid), .ser_out(ser_out),
    .ser_sof(ser_sof), .ser_busy(ser_busy), .frame_count(frame_count));

  hamming_frame_encoder #(.GAP_CYCLES(0), .COUNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_ready(ready_b),
    .in_data(data_b), .in_parity_odd(odd_b), .in_err_pos(err_b),
    .cw_out(cw_b), .cw_odd(cw_odd_b), .cw_valid(cw_valid_b), .ser_out(ser_b),
    .ser_sof(sof_b), .ser_busy(busy_b), .frame_count(frame_count_b));

  typedef struct {
    logic [6:0] cw;
    logic       odd;
    logic [3:0] data;
    int         vcyc;
  } exp_t;

  typedef struct {
    logic [3:0] d;
    logic       odd;
    logic [2:0] e;
    logic [6:0] cw;
  } vec_t;

  exp_t sbq[$];
  int   sof_cyc[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   bit_i = 7;
  int   sof_cnt = 0;
  int   fc_model = 0;
  int   run_b = 0;
  int   max_run_b = 0;
  logic [6:0] sh_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout_or_unexpected expected=event at cycle %0d", name, cyc);
  endtask

  // Reference Hamming(7,4) decoder: syndrome bit i covers positions with bit i set.
  function automatic logic [3:0] hdec(input logic [6:0] c, input logic odd);
    logic [6:0] x;
    logic [2:0] s;
    x = c;
    s[0] = x[6] ^ x[4] ^ x[2] ^ x[0] ^ odd;
    s[1] = x[5] ^ x[4] ^ x[1] ^ x[0] ^ odd;
    s[2] = x[3] ^ x[2] ^ x[1] ^ x[0] ^ odd;
    if (s != 3'd0) x[7 - s] = ~x[7 - s];
    return {x[4], x[2], x[1], x[0]};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      bit_i    = 7;
      fc_model = 0;
    end else begin
      if (cw_valid) begin
        if (sbq.size() == 0) begin
          flag("unexpected_cw_valid");
        end else begin
          exp_t e;
          e = sbq.pop_front();
          fc_model = (fc_model + 1) % 4;
          chk("cw_out", cw_out, e.cw);
          chk("cw_odd", cw_odd, e.odd);
          chk("decoded", hdec(cw_out, cw_odd), e.data);
          chk("frame_count", frame_count, fc_model);
          if (e.vcyc >= 0) chk("latency", cyc, e.vcyc);
          sh_exp = e.cw;
          bit_i  = 0;
        end
      end
      if (ser_busy) begin
        if (bit_i < 7) begin
          chk("ser_bit", ser_out, sh_exp[6 - bit_i]);
          chk("ser_sof", ser_sof, (bit_i == 0));
          bit_i++;
        end else begin
          flag("ser_extra_bit");
        end
      end else if (ser_out || ser_sof) begin
        flag("ser_idle_activity");
      end
      if (ser_sof) begin
        sof_cyc.push_back(cyc);
        sof_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (busy_b) run_b++;
    else begin
      if (run_b > max_run_b) max_run_b = run_b;
      run_b = 0;
    end
  end

  task automatic send(input logic [3:0] d, input logic odd, input logic [2:0] e,
                      input logic [6:0] cw, input bit timed);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_parity_odd = odd; in_err_pos = e;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) flag("timeout_ready");
    else sbq.push_back('{cw: cw, odd: odd, data: d, vcyc: timed ? cyc + 2 : -1});
    @(negedge clk);
    in_valid = 1'b0; in_data = 4'hx; in_err_pos = 3'd0;
  endtask

  task automatic send_b(input logic [3:0] d);
    int n = 0;
    vb = 1'b1; data_b = d; odd_b = 1'b0; err_b = 3'd0;
    while (!ready_b && n < 50) begin @(negedge clk); n++; end
    if (!ready_b) flag("timeout_ready_b");
    @(negedge clk);
    vb = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sbq.size() != 0 || ser_busy) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) flag("timeout_idle");
    repeat (2) @(negedge clk);
  endtask

  vec_t vecs[8];
  vec_t burst[5];

  initial begin
    int n;
    int sof_base;
    vecs[0] = '{4'b1011, 1'b0, 3'd0, 7'b0110011};
    vecs[1] = '{4'b1011, 1'b1, 3'd0, 7'b1011011};
    vecs[2] = '{4'b0000, 1'b1, 3'd0, 7'b1101000};
    vecs[3] = '{4'b0000, 1'b0, 3'd0, 7'b0000000};
    vecs[4] = '{4'b1011, 1'b0, 3'd3, 7'b0100011};
    vecs[5] = '{4'b1011, 1'b0, 3'd7, 7'b0110010};
    vecs[6] = '{4'b1000, 1'b0, 3'd1, 7'b0110000};
    vecs[7] = '{4'b0110, 1'b1, 3'd0, 7'b0001110};
    burst[0] = '{4'b0001, 1'b0, 3'd0, 7'b1101001};
    burst[1] = '{4'b1111, 1'b0, 3'd0, 7'b1111111};
    burst[2] = '{4'b0110, 1'b1, 3'd0, 7'b0001110};
    burst[3] = '{4'b1011, 1'b0, 3'd0, 7'b0110011};
    burst[4] = '{4'b0000, 1'b1, 3'd0, 7'b1101000};

    in_valid = 1'b0; in_data = 4'h0; in_parity_odd = 1'b0; in_err_pos = 3'd0;
    vb = 1'b0; data_b = 4'h0; odd_b = 1'b0; err_b = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_cw_out", cw_out, 7'd0);
    chk("rst_cw_valid", cw_valid, 1'b0);
    chk("rst_ser_busy", ser_busy, 1'b0);
    chk("rst_frame_count", frame_count, 2'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].d, vecs[i].odd, vecs[i].e, vecs[i].cw, 1'b1);
      wait_idle();
    end
    chk("idle_cw_hold", cw_out, 7'b0001110);

    // Burst of three with in_valid held: ready drops after accept, SOF every 9 cycles.
    sof_cyc.delete();
    in_valid = 1'b1; in_data = 4'b0001; in_parity_odd = 1'b0; in_err_pos = 3'd0;
    @(negedge clk);
    chk("ready_drop_after_accept", in_ready, 1'b0);
    sbq.push_back('{cw: burst[0].cw, odd: 1'b0, data: burst[0].d, vcyc: -1});
    in_valid = 1'b0;
    send(burst[1].d, burst[1].odd, burst[1].e, burst[1].cw, 1'b0);
    send(burst[2].d, burst[2].odd, burst[2].e, burst[2].cw, 1'b0);
    wait_idle();
    chk("burst_sof_count", sof_cyc.size(), 3);
    if (sof_cyc.size() == 3) begin
      chk("gap_spacing_1", sof_cyc[1] - sof_cyc[0], 9);
      chk("gap_spacing_2", sof_cyc[2] - sof_cyc[1], 9);
    end

    // Gapless instance: three words must give one unbroken 21-cycle busy run.
    send_b(4'b0001);
    send_b(4'b1111);
    send_b(4'b1011);
    repeat (25) @(negedge clk);
    chk("b_contiguous_busy", max_run_b, 21);
    chk("b_frame_count", frame_count_b, 8'd3);
    chk("b_last_cw", cw_b, 7'b0110011);

    // Async reset during serial bit 3 with a second word sitting in hold.
    send(4'b1111, 1'b0, 3'd0, 7'b1111111, 1'b1);
    send(4'b0001, 1'b0, 3'd0, 7'b1101001, 1'b0);
    n = 0;
    while (bit_i != 4 && n < 50) begin @(negedge clk); n++; end
    if (bit_i != 4) flag("timeout_bit3");
    #1;
    chk("pre_rst_busy", ser_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    sbq.delete();
    chk("mid_rst_ser_busy", ser_busy, 1'b0);
    chk("mid_rst_ser_out", ser_out, 1'b0);
    chk("mid_rst_ser_sof", ser_sof, 1'b0);
    chk("mid_rst_cw_out", cw_out, 7'd0);
    chk("mid_rst_cw_odd", cw_odd, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_frame_count", frame_count, 2'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sof_base = sof_cnt;
    repeat (20) @(negedge clk);
    chk("no_sof_after_rst", sof_cnt, sof_base);

    // Five frames on the 2-bit counter: monitor expects 1,2,3,0,1.
    for (int i = 0; i < 5; i++) send(burst[i].d, burst[i].odd, burst[i].e, burst[i].cw, 1'b0);
    wait_idle();
    chk("wrap_frame_count", frame_count, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
